// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port of the UART boot loader: req/gnt handshake carrying address and data.
interface uart_prog_loader_if;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;

  modport master (output req_o, output addr_o, output wdata_o, input gnt_i);
  modport slave  (input req_o, input addr_o, input wdata_o, output gnt_i);
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives bytes, packs little-endian words and writes them to instruction memory.
// Optional even-parity framing and parity_err_o port are enabled by defining UART_PROG_PARITY_EN.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               prog_en_i,
  input  logic               rx_i,
  uart_prog_loader_if.master mem,
  output logic               busy_o,
  output logic               done_o,
  output logic               frame_err_o,
  output logic               overrun_o
`ifdef UART_PROG_PARITY_EN
  ,
  output logic               parity_err_o
`endif
);

  localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_PARITY = 3'd3,
    R_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } top_state_e;

`ifdef UART_PROG_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_e   rx_state_r, rx_state_s;
  logic [15:0] cnt_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r, byte_r;
  logic        byte_vld_r;
  logic        cnt_hit_s, bit_smp_s, byte_ok_s, frame_bad_s;
`ifdef UART_PROG_PARITY_EN
  logic        par_smp_s, parity_bad_s, par_bad_r;
`endif

  top_state_e  state_r, state_s;
  logic        prog_en_prev_r, prog_rise_s, start_s, grant_s, word_done_s;
  logic [1:0]  lane_r;
  logic [23:0] word_r;
  logic [31:0] word_s;

  // The start bit is judged at mid-bit; every later bit is one full bit period apart.
  assign cnt_hit_s   = (rx_state_r == R_START) ? (cnt_r == HALF_C) : (cnt_r == LAST_C);
  assign prog_rise_s = prog_en_i & ~prog_en_prev_r;
  assign start_s     = prog_rise_s & ((state_r == IDLE) | (state_r == DONE));
  assign grant_s     = mem.req_o & mem.gnt_i;
  assign word_done_s = byte_vld_r & (lane_r == 2'd3);
  assign word_s      = {byte_r, word_r};

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX bit FSM next state and sampling strobes.
  always_comb begin
    rx_state_s  = rx_state_r;
    bit_smp_s   = 1'b0;
    byte_ok_s   = 1'b0;
    frame_bad_s = 1'b0;
`ifdef UART_PROG_PARITY_EN
    par_smp_s    = 1'b0;
    parity_bad_s = 1'b0;
`endif
    if (busy_o) begin
      case (rx_state_r)
        R_IDLE: begin
          if (rx_prev_r && !rx_sync_r) rx_state_s = R_START;
          else                         rx_state_s = R_IDLE;
        end
        R_START: begin
          if (cnt_hit_s) rx_state_s = rx_sync_r ? R_IDLE : R_DATA;
          else           rx_state_s = R_START;
        end
        R_DATA: begin
          if (cnt_hit_s) begin
            bit_smp_s = 1'b1;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_PROG_PARITY_EN
              rx_state_s = R_PARITY;
`else
              rx_state_s = R_STOP;
`endif
            end else begin
              rx_state_s = R_DATA;
            end
          end else begin
            rx_state_s = R_DATA;
          end
        end
`ifdef UART_PROG_PARITY_EN
        R_PARITY: begin
          if (cnt_hit_s) begin
            par_smp_s  = 1'b1;
            rx_state_s = R_STOP;
          end else begin
            rx_state_s = R_PARITY;
          end
        end
`endif
        R_STOP: begin
          if (cnt_hit_s) begin
            rx_state_s = R_IDLE;
            if (!rx_sync_r) frame_bad_s = 1'b1;
`ifdef UART_PROG_PARITY_EN
            else if (par_bad_r) parity_bad_s = 1'b1;
`endif
            else byte_ok_s = 1'b1;
          end else begin
            rx_state_s = R_STOP;
          end
        end
        default: rx_state_s = R_IDLE;
      endcase
    end else begin
      rx_state_s = R_IDLE;
    end
  end

  // RX state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state_r <= R_IDLE;
    else         rx_state_r <= rx_state_s;
  end

  // Bit timing counter, shift register and received-byte strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r      <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      byte_r     <= 8'd0;
      byte_vld_r <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      par_bad_r  <= 1'b0;
`endif
    end else begin
      if (rx_state_r == R_IDLE || cnt_hit_s || !busy_o) cnt_r <= 16'd0;
      else                                              cnt_r <= cnt_r + 16'd1;
      if (rx_state_r == R_START) bit_idx_r <= 3'd0;
      else if (bit_smp_s)        bit_idx_r <= bit_idx_r + 3'd1;
      if (bit_smp_s) shift_r <= {rx_sync_r, shift_r[7:1]};
      byte_vld_r <= byte_ok_s;
      if (byte_ok_s) byte_r <= shift_r;
`ifdef UART_PROG_PARITY_EN
      if (rx_state_r == R_START) par_bad_r <= 1'b0;
      else if (par_smp_s)        par_bad_r <= rx_sync_r ^ even_parity(shift_r);
`endif
    end
  end

  // Top session FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (prog_rise_s) state_s = RECV;
        else             state_s = IDLE;
      end
      RECV: begin
        if (!prog_en_i)       state_s = IDLE;
        else if (word_done_s) state_s = (word_s == END_WORD) ? DONE : WRITE;
        else                  state_s = RECV;
      end
      WRITE: begin
        if (grant_s) state_s = prog_en_i ? RECV : IDLE;
        else         state_s = WRITE;
      end
      DONE: begin
        if (prog_rise_s) state_s = RECV;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Top state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Registered bus outputs, status and word assembly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_en_prev_r <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      mem.req_o      <= 1'b0;
      mem.addr_o     <= BASE_ADDR;
      mem.wdata_o    <= 32'd0;
      lane_r         <= 2'd0;
      word_r         <= 24'd0;
    end else begin
      prog_en_prev_r <= prog_en_i;
      busy_o         <= (state_s == RECV) || (state_s == WRITE);
      done_o         <= (state_s == DONE);
      mem.req_o      <= (state_s == WRITE);
      if (state_r == RECV && state_s == WRITE) mem.wdata_o <= word_s;
      if (start_s)      mem.addr_o <= BASE_ADDR;
      else if (grant_s) mem.addr_o <= mem.addr_o + 32'd4;
      // A word finishing during WRITE still wraps the lane so framing stays aligned.
      if (start_s || state_s == IDLE) begin
        lane_r <= 2'd0;
      end else if (byte_vld_r) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0:    word_r[7:0]   <= byte_r;
          2'd1:    word_r[15:8]  <= byte_r;
          2'd2:    word_r[23:16] <= byte_r;
          default: word_r        <= word_r;
        endcase
      end
    end
  end

  // Sticky error flags, cleared at each session start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else if (start_s) begin
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_PROG_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      if (frame_bad_s) frame_err_o <= 1'b1;
      if (state_r == WRITE && word_done_s) overrun_o <= 1'b1;
`ifdef UART_PROG_PARITY_EN
      if (parity_bad_s) parity_err_o <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: serial stimulus against a byte/word-level reference model.
module tb_uart_prog_loader;
  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;

  logic clk = 1'b0, rst_n = 1'b0, prog_en = 1'b0, rx = 1'b1;
  logic busy, done, ferr, ovr;

  uart_prog_loader_if mem_if();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .END_WORD(ENDW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .prog_en_i(prog_en), .rx_i(rx), .mem(mem_if),
    .busy_o(busy), .done_o(done), .frame_err_o(ferr), .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int gnt_mode = 0;   // 0: always grant, 1: grant after 5 stall cycles, 2: never grant
  int stab_bad = 0;
  int g_cnt = 0;
  logic [31:0] g_a0, g_d0;

  // reference model: bytes -> little-endian words -> expected writes
  int          m_lane;
  logic [31:0] m_word, m_addr;
  logic        m_busy, m_done, m_ferr, m_ovr, m_outstanding;
  logic [31:0] exp_addr_q[$], exp_data_q[$], obs_addr_q[$], obs_data_q[$];

  function automatic void model_clear(input logic session);
    m_lane = 0; m_word = 32'd0; m_addr = BASE; m_busy = session; m_done = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0; m_outstanding = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic stop);
    if (!stop) begin
      m_ferr = 1'b1;
    end else begin
      m_word[8*m_lane +: 8] = b;
      if (m_lane == 3) begin
        m_lane = 0;
        if (m_word == ENDW) begin
          m_done = 1'b1; m_busy = 1'b0;
        end else if (m_outstanding && gnt_mode == 2) begin
          m_ovr = 1'b1;
        end else begin
          exp_addr_q.push_back(m_addr); exp_data_q.push_back(m_word);
          m_addr = m_addr + 32'd4; m_outstanding = 1'b1;
        end
      end else begin
        m_lane++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // grant driver and write monitor; a write is recorded when req && gnt hold into the next posedge
  initial begin
    mem_if.gnt_i = 1'b1;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        0: mem_if.gnt_i = 1'b1;
        1: begin
          if (mem_if.req_o) begin
            if (g_cnt == 0) begin g_a0 = mem_if.addr_o; g_d0 = mem_if.wdata_o; end
            else if (mem_if.addr_o !== g_a0 || mem_if.wdata_o !== g_d0) stab_bad++;
            if (g_cnt == 5) begin mem_if.gnt_i = 1'b1; g_cnt = 0; end
            else begin mem_if.gnt_i = 1'b0; g_cnt++; end
          end else begin
            if (g_cnt != 0) stab_bad++;
            mem_if.gnt_i = 1'b0; g_cnt = 0;
          end
        end
        default: mem_if.gnt_i = 1'b0;
      endcase
      if (rst_n && mem_if.req_o && mem_if.gnt_i) begin
        obs_addr_q.push_back(mem_if.addr_o); obs_data_q.push_back(mem_if.wdata_o);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) @(negedge clk); end
    rx = stop; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (6) @(negedge clk);
    model_byte(b, stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom(); while (w == ENDW);
    return w;
  endfunction

  task automatic check_flags(input string tag);
    check({tag, " busy"}, busy, m_busy);
    check({tag, " done"}, done, m_done);
    check({tag, " frame_err"}, ferr, m_ferr);
    check({tag, " overrun"}, ovr, m_ovr);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, " nwrites"}, 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
    n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
    end
    obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  task automatic start_session();
    prog_en = 1'b0; repeat (3) @(negedge clk);
    prog_en = 1'b1; repeat (3) @(negedge clk);
    model_clear(1'b1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; #1;
    model_clear(1'b0);
    check({tag, " req"}, mem_if.req_o, 1'b0);
    check({tag, " addr"}, mem_if.addr_o, BASE);
    check({tag, " wdata"}, mem_if.wdata_o, 32'd0);
    check_flags(tag);
    rx = 1'b1; prog_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; @(negedge clk);
    obs_addr_q.delete(); obs_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  logic [31:0] w0;
  logic [7:0]  b0, b1;

  initial begin
    do_reset("reset");

    // basic word then terminator, grant always high
    gnt_mode = 0; start_session();
    check("t1 start busy", busy, 1'b1);
    send_frame(8'h78, 1'b1); send_frame(8'h56, 1'b1); send_frame(8'h34, 1'b1); send_frame(8'h12, 1'b1);
    check("t1 word", exp_data_q[0], 32'h1234_5678);
    send_frame(8'hFF, 1'b1); send_frame(8'h0F, 1'b1); send_frame(8'h00, 1'b1); send_frame(8'h00, 1'b1);
    check_writes("t1"); check_flags("t1");
    check("t1 addr", mem_if.addr_o, 32'd4);

    // three random words with stalled grant
    gnt_mode = 1; stab_bad = 0; start_session();
    check("t2 start addr", mem_if.addr_o, BASE);
    for (int i = 0; i < 3; i++) send_word(rand_word());
    send_word(ENDW);
    check_writes("t2"); check_flags("t2");
    check("t2 stable", 32'(stab_bad), 32'd0);
    check("t2 addr", mem_if.addr_o, 32'd12);

    // framing error then a clean word
    gnt_mode = 0; start_session();
    send_frame(8'hA5, 1'b0);
    send_word(rand_word());
    check_writes("t3"); check_flags("t3");

    // single-cycle glitch between bytes of a word
    start_session();
    b0 = 8'($urandom()); b1 = 8'($urandom());
    send_frame(b0, 1'b1); send_frame(b1, 1'b1);
    rx = 1'b0; @(negedge clk); rx = 1'b1; repeat (20) @(negedge clk);
    send_frame(8'($urandom()), 1'b1); send_frame(8'($urandom()), 1'b1);
    send_word(ENDW);
    check_writes("t4"); check_flags("t4");

    // overrun while grant held low
    gnt_mode = 2; start_session();
    w0 = rand_word(); send_word(w0);
    check("t5 req held", mem_if.req_o, 1'b1);
    check("t5 addr held", mem_if.addr_o, BASE);
    check("t5 wdata held", mem_if.wdata_o, w0);
    send_word(rand_word());
    check_flags("t5 ovr");
    check("t5 no write yet", 32'(obs_addr_q.size()), 32'd0);
    gnt_mode = 0; repeat (4) @(negedge clk); m_outstanding = 1'b0;
    check_writes("t5a");
    send_word(rand_word()); send_word(ENDW);
    check_writes("t5b"); check_flags("t5b");
    check("t5 addr", mem_if.addr_o, m_addr);

    // reset mid-byte, reset mid-write, then a clean session
    start_session(); send_word(rand_word()); check_writes("t6a");
    rx = 1'b0; repeat (3 * CPB) @(negedge clk);
    do_reset("t6 midbyte");
    gnt_mode = 2; start_session(); send_word(rand_word());
    check("t6 req before", mem_if.req_o, 1'b1);
    do_reset("t6 midwrite");
    gnt_mode = 0; start_session();
    send_word(rand_word()); send_word(rand_word()); send_word(ENDW);
    check_writes("t6b"); check_flags("t6b");
    check("t6 addr", mem_if.addr_o, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- SoC-side receiving end of the UART boot-programming link.
- Samples the serial line from the board/bench programmer and assembles bytes into little-endian 32-bit words.
- Writes each word to instruction memory through a req/gnt write port at auto-incrementing addresses.
- Flags completion when the end-of-program word arrives; core reset release is gated on `done_o`.

Parameters:
- CLKS_PER_BIT, 347, system clocks per UART bit (40 MHz / 115200); must be ≥ 4.
- BASE_ADDR, 32'h0000_0000, first write address.
- END_WORD, 32'h0000_0FFF, terminator word; never written to memory.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- prog_en_i  input  1  programming enable; rising edge starts a session
- rx_i  input  1  UART serial in, idle high, asynchronous to clk_i
- req_o  output  1  memory write request
- gnt_i  input  1  memory grant; write completes in the cycle req_o && gnt_i
- addr_o  output  32  write byte address
- wdata_o  output  32  write data
- busy_o  output  1  session active
- done_o  output  1  terminator received
- frame_err_o  output  1  sticky: stop bit sampled low
- overrun_o  output  1  sticky: word completed while previous write pending

Behaviour:
- Reset (async assert, sync deassert) values:
  - `req_o`, `busy_o`, `done_o`, `frame_err_o`, `overrun_o` = 0.
  - `addr_o` = BASE_ADDR; `wdata_o` = 0.
  - Byte/bit counters = 0; top FSM in IDLE.
- `rx_i` passes through a 2-flop synchronizer. All timing below is from the synchronized signal (2-cycle input latency).
- RX bit FSM (states R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: falling edge → R_START, counter cleared.
  - R_START: at count CLKS_PER_BIT/2 (integer division), if line is still low → R_DATA. If high, it is a glitch → R_IDLE.
  - R_DATA: samples 8 bits, LSB first, every CLKS_PER_BIT clocks from mid-start.
  - R_STOP: samples the stop bit one CLKS_PER_BIT later.
    - Stop bit = 1: byte valid for one cycle.
    - Stop bit = 0: sets `frame_err_o`, byte discarded, byte-lane counter unchanged.
    - Either way → R_IDLE.
  - The RX FSM runs only while `busy_o` = 1; otherwise it is held in R_IDLE.
- Word assembly:
  - Valid byte n (0..3) goes to bits [8n+7:8n].
  - After the 4th byte the word is complete and the lane counter wraps to 0.
- Top FSM (states IDLE, RECV, WRITE, DONE):
  - IDLE → RECV on `prog_en_i` rising edge. Entering RECV: `busy_o` = 1, `done_o` = 0, `addr_o` = BASE_ADDR, lane counter = 0.
  - RECV, word complete and equal to END_WORD → DONE: `busy_o` = 0, `done_o` = 1, no write issued.
  - RECV, word complete otherwise → WRITE: `wdata_o` loaded, `req_o` = 1 the next cycle.
  - WRITE:
    - `req_o`, `addr_o`, `wdata_o` are held stable until `gnt_i`.
    - On the grant cycle: `req_o` = 0 next cycle, `addr_o` += 4 (32-bit wrap, no saturation), → RECV.
    - Bytes keep arriving during WRITE. If a 4th byte completes while still in WRITE, that word is dropped, `overrun_o` is set, and the lane counter wraps.
  - DONE: holds until the next `prog_en_i` rising edge, which starts a new session from BASE_ADDR → RECV.
- `prog_en_i` low in RECV → IDLE: partial word discarded, `busy_o` = 0.
- `prog_en_i` low in WRITE: the pending write completes on grant first, then → IDLE.
- Sticky flags clear only on reset or a new session start.
- A `gnt_i` without `req_o` is ignored.

Optional Feature:
- Macro: UART_PROG_PARITY_EN.
- Defined:
  - A 9th even-parity bit is expected between D7 and stop.
  - Adds output `parity_err_o` (1 bit, sticky, reset 0).
  - Parity mismatch sets it; the byte is discarded like a framing error.
- Not defined:
  - 8N1 framing.
  - No `parity_err_o` port.

Test Plan:
1. CLKS_PER_BIT=8, `prog_en_i` rising, send bytes 78 56 34 12 then FF 0F 00 00, `gnt_i` tied 1 → exactly one write: `addr_o`=0, `wdata_o`=32'h1234_5678; then `done_o`=1, `busy_o`=0, `addr_o`=4.
2. Three words then terminator, `gnt_i` delayed 5 cycles per request → `req_o` and data stable through the stall; writes at 0, 4, 8 in order; `done_o` set.
3. Byte A5 with stop bit 0, then a valid 4-byte word → `frame_err_o`=1; written word consists of the four valid bytes only.
4. 1-cycle low glitch on `rx_i` in R_IDLE → no byte, no error, lane counter unchanged.
5. `gnt_i` held 0 across 4 more full bytes → `overrun_o`=1; only the first word written once `gnt_i` rises.
6. Reset asserted mid-byte and mid-WRITE → all outputs return to reset values immediately; new session programs from BASE_ADDR correctly.
